// File: rtl/pixel_sink.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_sink
//  Brief    : Receiving end of the graphing-unit pixel stream. Clips
//             off-screen pixels, buffers on-screen ones in a small FIFO and
//             drains them into the framebuffer write port. Also runs a
//             full-screen clear sweep on request.
//  Revision : 1.0  initial release
// ============================================================================
module pixel_sink #(
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  x_in,
  input  logic [7:0]  y_in,
  input  logic [2:0]  colour_in,
  input  logic        writeEn,
  input  logic        clear,
  input  logic [2:0]  clear_colour,
  output logic        fifo_full,
  output logic        overflow,
  output logic        busy,
  output logic [16:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_we,
  output logic [15:0] pixel_count,
  output logic [7:0]  clip_count
);

  // FIFO pointer width; depth is a power of two so pointers wrap naturally.
  localparam int              c_AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_AW:0]   c_FULL_CNT  = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [9:0]      c_X_LIM     = 10'(SCREEN_W);
  localparam logic [8:0]      c_Y_LIM     = 9'(SCREEN_H);
  localparam logic [16:0]     c_W17       = 17'(SCREEN_W);
  localparam logic [16:0]     c_LAST_ADDR = 17'(SCREEN_W * SCREEN_H - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  // FIFO storage: {x, y, colour}
  logic [19:0]     r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;

  // Pop stage: entry read out of the FIFO, written to the framebuffer next edge.
  logic            r_stg_valid;
  logic [8:0]      r_stg_x;
  logic [7:0]      r_stg_y;
  logic [2:0]      r_stg_c;

  // Control / output registers
  state_t          r_state;
  logic [16:0]     r_sweep;
  logic [2:0]      r_clr_colour;
  logic            r_busy;
  logic            r_overflow;
  logic [16:0]     r_fb_addr;
  logic [2:0]      r_fb_data;
  logic            r_fb_we;
  logic [15:0]     r_pixel_count;
  logic [7:0]      r_clip_count;

  logic            w_x_ok;
  logic            w_y_ok;
  logic            w_in_bounds;
  logic            w_clip;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [19:0]     w_head;
  logic [16:0]     w_stg_addr;

  assign w_x_ok      = ({1'b0, x_in} < c_X_LIM);
  assign w_y_ok      = ({1'b0, y_in} < c_Y_LIM);
  assign w_in_bounds = writeEn && w_x_ok && w_y_ok;
  assign w_clip      = writeEn && !(w_x_ok && w_y_ok);
  assign w_full      = (r_count == c_FULL_CNT);
  assign w_empty     = (r_count == '0);

  // No pop on the edge a clear is accepted, so the first sweep write never
  // collides with a stream write coming out of the pop stage.
  assign w_pop       = (r_state == S_IDLE) && !clear && !w_empty;
  assign w_push      = w_in_bounds && (!w_full || w_pop);
  assign w_drop      = w_in_bounds && w_full && !w_pop;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_stg_addr  = 17'(r_stg_y) * c_W17 + 17'(r_stg_x);

  // FIFO storage write (no reset needed: occupancy tracks validity)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {x_in, y_in, colour_in};
    end
  end

  // FIFO pointers and occupancy; push and pop together keep the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Pop stage register holding the entry leaving the FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stg_valid <= 1'b0;
      r_stg_x     <= '0;
      r_stg_y     <= '0;
      r_stg_c     <= '0;
    end else begin
      r_stg_valid <= w_pop;
      if (w_pop) begin
        r_stg_x <= w_head[19:11];
        r_stg_y <= w_head[10:3];
        r_stg_c <= w_head[2:0];
      end
    end
  end

  // Sticky overflow and saturating clip counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_clip_count <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_clip && (r_clip_count != 8'hFF)) begin
        r_clip_count <= r_clip_count + 1'b1;
      end
    end
  end

  // Sink FSM: stream writes in idle, full-screen sweep in clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_sweep       <= '0;
      r_clr_colour  <= '0;
      r_busy        <= 1'b0;
      r_fb_addr     <= '0;
      r_fb_data     <= '0;
      r_fb_we       <= 1'b0;
      r_pixel_count <= '0;
    end else begin
      r_fb_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_stg_valid) begin
            r_fb_we       <= 1'b1;
            r_fb_addr     <= w_stg_addr;
            r_fb_data     <= r_stg_c;
            r_pixel_count <= r_pixel_count + 1'b1;
          end
          if (clear) begin
            r_state      <= S_CLEAR;
            r_busy       <= 1'b1;
            r_sweep      <= '0;
            r_clr_colour <= clear_colour;
          end
        end
        S_CLEAR: begin
          r_fb_we   <= 1'b1;
          r_fb_addr <= r_sweep;
          r_fb_data <= r_clr_colour;
          if (r_sweep == c_LAST_ADDR) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_sweep <= r_sweep + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_full   = w_full;
  assign overflow    = r_overflow;
  assign busy        = r_busy;
  assign fb_addr     = r_fb_addr;
  assign fb_data     = r_fb_data;
  assign fb_we       = r_fb_we;
  assign pixel_count = r_pixel_count;
  assign clip_count  = r_clip_count;

endmodule
`default_nettype wire
